// File: rtl/draw_arbiter.sv
// Pixel-draw arbiter: grants one requester for a whole sprite/region burst and
// forwards each accepted pixel to the VGA write port one cycle later.
//
// state  | meaning
// IDLE   | arbitration cycle; no ready asserted, winner registered if any valid
// LOCKED | grant held on gsel; pixels accepted while ~hold until burst ends
module draw_arbiter #(
  parameter int NUM_CH      = 9,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int RR_MODE     = 0,
  parameter int BURST_LIMIT = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_last,
  input  logic [NUM_CH*X_W-1:0]    ch_x,
  input  logic [NUM_CH*Y_W-1:0]    ch_y,
  input  logic [NUM_CH*COLOUR_W-1:0] ch_colour,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic                     hold,
  output logic [X_W-1:0]           X,
  output logic [Y_W-1:0]           Y,
  output logic [COLOUR_W-1:0]      COLOUR,
  output logic                     writeEn,
  output logic [3:0]               grant_id,
  output logic                     busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (BURST_LIMIT > 1) ? $clog2(BURST_LIMIT + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [CH_W-1:0]   gsel;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   win_idx;
  logic              win_found;
  logic [CNT_W-1:0]  burst_left;
  logic              g_valid;
  logic              g_last;
  logic              burst_end;

  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    win_found = 1'b0;
    if (RR_MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_valid[CH_W'(i)]) begin
          win_idx   = CH_W'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      // search starts strictly after the last granted channel
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!win_found && ch_valid[CH_W'(idx)]) begin
          win_idx   = CH_W'(idx);
          win_found = 1'b1;
        end
      end
    end
  end

  assign g_valid   = ch_valid[gsel];
  assign g_last    = ch_last[gsel];
  // down-counter loaded at grant; terminal count on the transfer that hits 1
  assign burst_end = (BURST_LIMIT != 0) && (burst_left == CNT_W'(1));
  assign grant_id  = 4'(gsel);
  assign busy      = (state == LOCKED);

  always_comb begin
    ch_ready = '0;
    if (state == LOCKED) ch_ready[gsel] = ~hold;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gsel       <= '0;
      rr_ptr     <= CH_W'(NUM_CH - 1);
      burst_left <= '0;
      X          <= '0;
      Y          <= '0;
      COLOUR     <= '0;
      writeEn    <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gsel       <= win_idx;
            burst_left <= CNT_W'(BURST_LIMIT);
            state      <= LOCKED;
          end
        end
        LOCKED: begin
          if (!hold) begin
            if (g_valid) begin
              X          <= ch_x[gsel*X_W +: X_W];
              Y          <= ch_y[gsel*Y_W +: Y_W];
              COLOUR     <= ch_colour[gsel*COLOUR_W +: COLOUR_W];
              writeEn    <= 1'b1;
              burst_left <= burst_left - 1'b1;
            end
            // dropped valid while not stalled means the requester abandoned
            if (!g_valid || g_last || burst_end) begin
              state      <= IDLE;
              rr_ptr     <= gsel;
              burst_left <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: three instances (fixed, round-robin, round-robin with
// burst limit 4) share one requester model; a queue holds the predicted writes.
module tb_draw_arbiter;
  localparam int N = 9;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } pix_t;

  typedef struct {
    int           dut;
    logic [N-1:0] mask;
    bit           busy;
    int           grant;
  } row_t;

  logic clock = 1'b0;
  logic reset;
  logic hold;
  logic [N-1:0]   ch_valid;
  logic [N-1:0]   ch_last;
  logic [N*8-1:0] ch_x;
  logic [N*7-1:0] ch_y;
  logic [N*3-1:0] ch_colour;

  logic [N-1:0] rdy [3];
  logic [7:0]   ox  [3];
  logic [6:0]   oy  [3];
  logic [2:0]   oc  [3];
  logic         wen [3];
  logic [3:0]   gid [3];
  logic         bsy [3];

  always #5 clock = ~clock;

  draw_arbiter #(.NUM_CH(N), .RR_MODE(0), .BURST_LIMIT(0)) u_fix (
    .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_last(ch_last),
    .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour), .ch_ready(rdy[0]),
    .hold(hold), .X(ox[0]), .Y(oy[0]), .COLOUR(oc[0]), .writeEn(wen[0]),
    .grant_id(gid[0]), .busy(bsy[0]));

  draw_arbiter #(.NUM_CH(N), .RR_MODE(1), .BURST_LIMIT(0)) u_rr (
    .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_last(ch_last),
    .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour), .ch_ready(rdy[1]),
    .hold(hold), .X(ox[1]), .Y(oy[1]), .COLOUR(oc[1]), .writeEn(wen[1]),
    .grant_id(gid[1]), .busy(bsy[1]));

  draw_arbiter #(.NUM_CH(N), .RR_MODE(1), .BURST_LIMIT(4)) u_bl (
    .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_last(ch_last),
    .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour), .ch_ready(rdy[2]),
    .hold(hold), .X(ox[2]), .Y(oy[2]), .COLOUR(oc[2]), .writeEn(wen[2]),
    .grant_id(gid[2]), .busy(bsy[2]));

  pix_t src [N][32];
  int   src_n  [N];
  int   src_rd [N];
  pix_t expq [$];
  int   wr_cyc [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   sel    = 0;
  logic hold_nx = 1'b0;
  logic [N-1:0] acc = '0;
  row_t rows [6];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc_no);
    end
  endtask

  task automatic add_pix(input int ch, input int x, input int y, input int c, input bit last);
    src[ch][src_n[ch]] = {8'(x), 7'(y), 3'(c), last};
    src_n[ch]++;
  endtask

  task automatic push_exp(input int x, input int y, input int c);
    pix_t p;
    p = {8'(x), 7'(y), 3'(c), 1'b0};
    expq.push_back(p);
  endtask

  // one clock: check the write produced by last cycle's acceptance, then drive
  task automatic cyc();
    pix_t p;
    @(negedge clock);
    cyc_no++;
    chk(wen[sel] == (|acc), "wen_latency", int'(wen[sel]), int'(|acc));
    if (wen[sel]) begin
      wr_cyc.push_back(cyc_no);
      if (expq.size() == 0) begin
        chk(1'b0, "unexpected_write", int'(ox[sel]), -1);
      end else begin
        p = expq.pop_front();
        chk(ox[sel] == p.x && oy[sel] == p.y && oc[sel] == p.c, "pixel",
            int'({ox[sel], oy[sel], oc[sel]}), int'({p.x, p.y, p.c}));
      end
    end
    for (int i = 0; i < N; i++) if (acc[i]) src_rd[i]++;
    hold = hold_nx;
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] < src_n[i]) begin
        p = src[i][src_rd[i]];
        ch_valid[i] = 1'b1;
        ch_last[i]  = p.last;
        ch_x[i*8 +: 8]      = p.x;
        ch_y[i*7 +: 7]      = p.y;
        ch_colour[i*3 +: 3] = p.c;
      end else begin
        ch_valid[i] = 1'b0;
        ch_last[i]  = 1'b0;
        ch_x[i*8 +: 8]      = '0;
        ch_y[i*7 +: 7]      = '0;
        ch_colour[i*3 +: 3] = '0;
      end
    end
    #1;
    acc = ch_valid & rdy[sel] & {N{~reset}};
  endtask

  task automatic assert_rst();
    reset = 1'b1;
    acc   = '0;
  endtask

  task automatic do_reset();
    expq.delete();
    for (int i = 0; i < N; i++) begin
      src_n[i]  = 0;
      src_rd[i] = 0;
    end
    hold_nx = 1'b0;
    assert_rst();
    cyc();
    cyc();
    reset = 1'b0;
    wr_cyc.delete();
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (src_rd[i] < src_n[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (n < budget && !done) begin
      cyc();
      n++;
      done = (expq.size() == 0) && !bsy[sel] && drained();
    end
    chk(done, "drain_timeout", n, budget);
    repeat (3) cyc();
  endtask

  task automatic chk_gaps(input string name, input int g0, input int g1, input int g2, input int rest);
    for (int i = 1; i < wr_cyc.size(); i++) begin
      int req;
      req = (i == 1) ? g0 : (i == 2) ? g1 : (i == 3) ? g2 : rest;
      chk(wr_cyc[i] - wr_cyc[i-1] == req, name, wr_cyc[i] - wr_cyc[i-1], req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{0, 9'h024, 1'b1, 2};
    rows[1] = '{0, 9'h100, 1'b1, 8};
    rows[2] = '{0, 9'h1FE, 1'b1, 1};
    rows[3] = '{0, 9'h000, 1'b0, 0};
    rows[4] = '{1, 9'h0A0, 1'b1, 5};
    rows[5] = '{2, 9'h101, 1'b1, 0};

    reset = 1'b1; hold = 1'b0;
    ch_valid = '0; ch_last = '0; ch_x = '0; ch_y = '0; ch_colour = '0;

    // reset state, all three instances
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk(ox[k] == 8'd0, "rst_x", int'(ox[k]), 0);
      chk(oy[k] == 7'd0, "rst_y", int'(oy[k]), 0);
      chk(oc[k] == 3'd0, "rst_colour", int'(oc[k]), 0);
      chk(wen[k] == 1'b0, "rst_wen", int'(wen[k]), 0);
      chk(rdy[k] == '0, "rst_ready", int'(rdy[k]), 0);
      chk(bsy[k] == 1'b0, "rst_busy", int'(bsy[k]), 0);
    end

    // arbitration table: grant held under hold, ready stays low
    for (int r = 0; r < 6; r++) begin
      sel = rows[r].dut;
      do_reset();
      hold_nx = 1'b1;
      for (int i = 0; i < N; i++) if (rows[r].mask[i]) add_pix(i, i, 0, 1, 1'b1);
      cyc();
      cyc();
      chk(bsy[sel] == rows[r].busy, "tbl_busy", int'(bsy[sel]), int'(rows[r].busy));
      if (rows[r].busy) chk(gid[sel] == 4'(rows[r].grant), "tbl_grant", int'(gid[sel]), rows[r].grant);
      chk(rdy[sel] == '0, "tbl_ready_hold", int'(rdy[sel]), 0);
    end

    // fixed priority: ch2 burst of 3 beats ch5, one idle cycle, then ch5
    sel = 0;
    do_reset();
    add_pix(2, 10, 20, 5, 1'b0); add_pix(2, 11, 20, 5, 1'b0); add_pix(2, 12, 20, 5, 1'b1);
    add_pix(5, 50, 30, 2, 1'b1);
    push_exp(10, 20, 5); push_exp(11, 20, 5); push_exp(12, 20, 5); push_exp(50, 30, 2);
    cyc();
    cyc();
    chk(gid[0] == 4'd2, "fix_grant", int'(gid[0]), 2);
    chk(bsy[0] == 1'b1, "fix_busy", int'(bsy[0]), 1);
    run_until_done(40);
    chk(wr_cyc.size() == 4, "fix_nwrites", wr_cyc.size(), 4);
    chk_gaps("fix_gap", 1, 1, 2, 0);

    // round robin: 0,1,3,0,1,3 single-pixel bursts, a write every 2 cycles
    sel = 1;
    do_reset();
    add_pix(0, 2, 1, 1, 1'b1);  add_pix(0, 2, 2, 1, 1'b1);
    add_pix(1, 17, 1, 2, 1'b1); add_pix(1, 17, 2, 2, 1'b1);
    add_pix(3, 49, 1, 3, 1'b1); add_pix(3, 49, 2, 3, 1'b1);
    push_exp(2, 1, 1); push_exp(17, 1, 2); push_exp(49, 1, 3);
    push_exp(2, 2, 1); push_exp(17, 2, 2); push_exp(49, 2, 3);
    run_until_done(60);
    chk(wr_cyc.size() == 6, "rr_nwrites", wr_cyc.size(), 6);
    chk_gaps("rr_gap", 2, 2, 2, 2);

    // hold for 4 cycles mid-burst on ch0
    sel = 0;
    do_reset();
    add_pix(0, 1, 10, 4, 1'b0); add_pix(0, 2, 10, 4, 1'b0); add_pix(0, 3, 10, 4, 1'b1);
    push_exp(1, 10, 4); push_exp(2, 10, 4); push_exp(3, 10, 4);
    cyc();
    cyc();
    hold_nx = 1'b1;
    for (int h = 0; h < 4; h++) begin
      cyc();
      chk(rdy[0] == '0, "hold_ready", int'(rdy[0]), 0);
      chk(gid[0] == 4'd0 && bsy[0], "hold_grant", int'({bsy[0], gid[0]}), 16);
    end
    hold_nx = 1'b0;
    run_until_done(40);

    // burst limit 4: ch1 streams 10 pixels, ch4 slots in after the first 4
    sel = 2;
    do_reset();
    for (int n = 0; n < 10; n++) add_pix(1, 16 + n, 1, 6, 1'b0);
    add_pix(4, 64, 4, 7, 1'b1);
    for (int n = 0; n < 4; n++) push_exp(16 + n, 1, 6);
    push_exp(64, 4, 7);
    for (int n = 4; n < 10; n++) push_exp(16 + n, 1, 6);
    run_until_done(80);

    // reset while locked on ch7 with a transfer in the same cycle
    sel = 1;
    do_reset();
    add_pix(3, 48, 3, 3, 1'b1);
    for (int n = 0; n < 4; n++) add_pix(7, 112 + n, 7, 7, 1'b0);
    push_exp(48, 3, 3); push_exp(112, 7, 7);
    cyc(); cyc(); cyc(); cyc();
    chk(gid[1] == 4'd7 && bsy[1], "rst_mid_grant", int'({bsy[1], gid[1]}), 16 + 7);
    cyc();
    assert_rst();
    add_pix(2, 32, 2, 2, 1'b1);
    push_exp(32, 2, 2);
    for (int n = 1; n < 4; n++) push_exp(112 + n, 7, 7);
    cyc();
    chk(bsy[1] == 1'b0, "rst_mid_busy", int'(bsy[1]), 0);
    reset = 1'b0;
    cyc();
    chk(gid[1] == 4'd2 && bsy[1], "rst_rearb_grant", int'({bsy[1], gid[1]}), 16 + 2);
    run_until_done(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
Parametrised pixel-draw arbiter between the game sprite/region generators (snake bodies, fruits, walls, screen clear) and the VGA adapter write port. It replaces static select-driven muxing with a request/ready handshake per channel. It locks a grant for a whole burst (one sprite or region) and supports fixed or round-robin priority. It emits one registered pixel write per accepted transfer.

Parameters:
NUM_CH, 9, number of draw channels (2..16)
X_W, 8, x-coordinate width
Y_W, 7, y-coordinate width
COLOUR_W, 3, colour width
RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
BURST_LIMIT, 0, 0 = unlimited; otherwise force grant release after this many pixels

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ch_valid  input  NUM_CH  channel i has a pixel on its bus
ch_last  input  NUM_CH  channel i's current pixel ends its burst
ch_x  input  NUM_CH*X_W  packed x; channel i at [i*X_W +: X_W]
ch_y  input  NUM_CH*Y_W  packed y
ch_colour  input  NUM_CH*COLOUR_W  packed colour
ch_ready  output  NUM_CH  one-hot; pixel accepted when ch_valid[i] & ch_ready[i]
hold  input  1  downstream stall; no transfers while high
X  output  X_W  registered pixel x
Y  output  Y_W  registered pixel y
COLOUR  output  COLOUR_W  registered pixel colour
writeEn  output  1  registered write strobe
grant_id  output  4  index of the locked channel (valid when busy)
busy  output  1  high in LOCKED

Behaviour:
- Reset (sync, active-high): state IDLE; X=0, Y=0, COLOUR=0, writeEn=0, grant_id=0, busy=0, ch_ready=0, burst counter=0, RR pointer=NUM_CH-1 (so channel 0 is searched first).
- States: IDLE, LOCKED.
- IDLE: if any ch_valid is high, select the winner:
  - Fixed mode: lowest index wins.
  - RR mode: first valid index strictly after the RR pointer, modulo NUM_CH.
  - Register grant_id and go to LOCKED next cycle. ch_ready is 0 throughout IDLE.
  - No valid channels: remain in IDLE.
- LOCKED:
  - ch_ready[grant_id] = ~hold. ch_ready is combinational from state, grant_id and hold. All other ready bits are 0.
  - Transfer = ch_valid[g] & ~hold.
  - On a transfer: next cycle X/Y/COLOUR = channel g's fields and writeEn=1 (latency 1). Otherwise writeEn=0 next cycle and X/Y/COLOUR hold their last values.
  - Burst counter increments on each transfer and clears on entering IDLE.
- LOCKED -> IDLE on any of:
  - a transfer with ch_last[g]=1;
  - ch_valid[g]=0 while hold=0 (abandoned burst; no write);
  - BURST_LIMIT≠0 and a transfer makes the counter reach BURST_LIMIT.
  - On exit, the RR pointer is set to g.
- There is always at least one idle cycle between bursts (the arbitration cycle). A channel can never receive two consecutive grants while another channel is valid in RR mode.
- hold high in LOCKED: no state change and no abandon check; the grant is kept.
- A valid on a non-granted channel is ignored until the next arbitration. Requesters must hold their data until ready.
- grant_id is zero-extended. NUM_CH>16 is unsupported.
- Reset mid-burst: returns to IDLE immediately; the in-flight pixel is dropped and writeEn=0 the next cycle.

Test Plan:
1. Reset with all inputs idle -> X=0, Y=0, COLOUR=0, writeEn=0, ch_ready=0, busy=0.
2. Fixed mode: channels 2 and 5 valid simultaneously, ch2 burst of 3 pixels (10,20),(11,20),(12,20) colour 3'b101 with last on the 3rd -> grant_id=2. writeEn high for 3 cycles, each 1 cycle after acceptance, with matching X/Y/COLOUR. Then 1 idle cycle, then ch5 granted.
3. RR mode: channels 0, 1, 3 continuously valid with single-pixel bursts (last=1) -> grant order 0, 1, 3, 0, 1, 3, with writeEn pulses every 2 cycles.
4. hold asserted for 4 cycles mid-burst on ch0 -> ch_ready=0 and writeEn=0 during hold. The same pixel is written once after hold drops, and grant_id is unchanged.
5. BURST_LIMIT=4, ch1 streams 10 pixels with no last, ch4 also valid, RR mode -> ch1 writes 4 pixels, ch4 is granted next, and ch1 resumes afterwards.
6. Reset pulsed while LOCKED on ch7 with a transfer in the same cycle -> next cycle writeEn=0, busy=0, then re-arbitration from channel 0.
